cordic_ctrl: RTL and testbench
==============================

Name: cordic_ctrl

Overview:
- Sequencer for the iterative CORDIC datapath.
- Accepts a start request and pulses the datapath register load.
- Drives the per-iteration enable and iteration index, which select the shift amount and the atan LUT address.
- Holds the result valid until downstream acknowledges; sits between the bus/CSR front end and the CORDIC rotation datapath.

Parameters:
- Iterations, 16, maximum number of micro-rotations supported.
- IterW, $clog2(Iterations), width of the iteration index and count fields.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  request a new operation; accepted only when ready_o=1.
- iters_i  input  IterW+1  requested iteration count; sampled on the accepted start.
- ack_i  input  1  downstream consumed the result; meaningful only while valid_o=1.
- ready_o  output  1  controller idle and able to accept start_i.
- load_o  output  1  one-cycle pulse; datapath loads x/y/z operands.
- iter_en_o  output  1  datapath performs one micro-rotation this cycle.
- iter_idx_o  output  IterW  current iteration index (0-based), shift amount / LUT address.
- valid_o  output  1  datapath result registers hold a completed result.
- busy_o  output  1  asserted in LOAD and RUN.

Behaviour:
- All outputs registered or decoded from registered state.
- Reset values: FSM=IDLE, ready_o=1, load_o=0, iter_en_o=0, iter_idx_o=0, valid_o=0, busy_o=0, latched count=0.
- FSM states IDLE, LOAD, RUN, DONE; state encoding defined in the package.
- IDLE:
  - ready_o=1.
  - start_i=1 -> LOAD next cycle; iters_i is latched into n_q.
  - n_q clamps: iters_i=0 or iters_i>Iterations gives n_q=Iterations.
- LOAD:
  - load_o=1 for exactly one cycle; iter_idx_o=0.
  - Next state is RUN unconditionally.
- RUN:
  - iter_en_o=1 every cycle.
  - iter_idx_o counts 0,1,...,n_q-1, incrementing after each enabled cycle.
  - On the cycle with iter_idx_o==n_q-1 -> DONE next cycle and the index wraps to 0.
- DONE:
  - valid_o=1, held until ack_i=1.
  - ack_i=1 -> IDLE next cycle; valid_o drops the same edge.
  - ack_i while valid_o=0 is ignored.
- Latency:
  - Start accept to load_o = 1 cycle.
  - Start accept to valid_o = n_q+2 cycles.
  - Minimum start-to-start spacing = n_q+3 cycles with ack_i held high.
- start_i outside IDLE is ignored (not queued).
- The iteration index never exceeds Iterations-1; no wrap beyond n_q-1.
- Asynchronous reset mid-RUN or mid-DONE: immediate return to reset values; no load_o or valid_o glitch after deassertion.
- start_i and ack_i both high in DONE: ack is honoured; start is ignored; ready_o rises the following cycle.

Optional Feature:
- Macro CORDIC_CTRL_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in LOAD or RUN -> IDLE next cycle, iter_idx_o=0, valid_o stays 0.
  - abort_i in IDLE/DONE is ignored; abort has priority over RUN completion on the same cycle.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package cordic_pkg:
  - typedef enum logic [1:0] cordic_state_e {IDLE, LOAD, RUN, DONE}.
  - localparam CordicIterationsDef=16.
  - Function clamp_iters.
- Sub-module cordic_iter_cnt (Width param):
  - Enable, synchronous clear, max input, count output, last-tick output.
  - Async active-high reset; instantiated once for iter_idx_o.

Test Plan:
- Reset then start_i=1 with iters_i=16 -> load_o at cycle 1; iter_en_o cycles 2..17 with idx 0..15; valid_o at cycle 18; ready_o=0 throughout.
- iters_i=0 and iters_i=20 (Iterations=16) -> both run exactly 16 iterations, idx 0..15.
- iters_i=1 -> a single iter_en_o cycle with idx=0; valid_o 3 cycles after start.
- valid_o held with ack_i=0 for 10 cycles, then ack_i=1 -> valid_o falls next edge; start_i pulsed during DONE is ignored.
- rst_i asserted asynchronously at idx=7 -> outputs reach reset values immediately; a new start after release begins at idx=0.
- With CORDIC_CTRL_ABORT_EN, abort_i at idx=5 -> IDLE next cycle, no valid_o, ready_o=1; a subsequent start completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC sequencer.
//   cordic_state_e      : controller FSM state encoding
//   CordicIterationsDef : default maximum micro-rotation count
//   clamp_iters()       : maps a requested count onto 1..max (0 or >max -> max)
package cordic_pkg;

  localparam int unsigned CordicIterationsDef = 16;
  localparam int unsigned CordicIterWDef      = $clog2(CordicIterationsDef);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } cordic_state_e;

  // A zero request means "full precision", as does anything beyond the LUT depth.
  function automatic int unsigned clamp_iters(input int unsigned req,
                                              input int unsigned max_iters);
    if (req == 0 || req > max_iters) begin
      return max_iters;
    end
    return req;
  endfunction

endpackage : cordic_pkg

// File: rtl/cordic_iter_cnt.sv
// Iteration index counter for the CORDIC sequencer.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : advance the count this cycle
//   clr_i        : synchronous clear (wins over en_i)
//   max_i        : number of counts per pass (count runs 0..max_i-1)
//   cnt_o        : current count (registered)
//   last_c_o     : combinational decode, count is max_i-1
module cordic_iter_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width:0]   max_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_c_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Compare in Width+1 bits so max_i == 2**Width is reachable.
  assign last_c_o = ((Width+1)'(cnt_q) + (Width+1)'(1)) == max_i;

  // Wrap to zero after the last count so the index never passes max_i-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_c_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : cordic_iter_cnt

// File: rtl/cordic_ctrl.sv
// Sequencer for the iterative CORDIC datapath: accepts a start, pulses the
// operand load, steps the micro-rotation index, then holds valid until ack.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : start request, taken only while ready_o
//   iters_i      : requested iteration count, sampled on accepted start
//   ack_i        : result consumed, honoured only while valid_o
//   abort_i      : (CORDIC_CTRL_ABORT_EN only) cancel from LOAD/RUN
//   ready_o      : idle, can accept start_i
//   load_o       : one-cycle operand load pulse
//   iter_en_o    : datapath performs one micro-rotation
//   iter_idx_o   : shift amount / atan LUT address
//   valid_o      : completed result held in datapath
//   busy_o       : in LOAD or RUN
// Build option: define CORDIC_CTRL_ABORT_EN to add abort_i.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter  int unsigned Iterations = CordicIterationsDef,
  localparam int unsigned IterW      = $clog2(Iterations)
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef CORDIC_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             start_i,
  input  logic [IterW:0]   iters_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             load_o,
  output logic             iter_en_o,
  output logic [IterW-1:0] iter_idx_o,
  output logic             valid_o,
  output logic             busy_o
);

  cordic_state_e state_q, state_d;
  logic [IterW:0] n_q, n_d;
  logic           last_c;
  logic           abort_c;
  logic           abort_act_c;

`ifdef CORDIC_CTRL_ABORT_EN
  assign abort_c = abort_i;
`else
  assign abort_c = 1'b0;
`endif

  // Abort only matters while an operation is in flight.
  assign abort_act_c = abort_c && (state_q == LOAD || state_q == RUN);

  // Next-state and count latch.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          n_d     = (IterW+1)'(clamp_iters(32'(iters_i), Iterations));
        end
      end
      LOAD:    state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort outranks completion on the same cycle.
    if (abort_act_c) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  cordic_iter_cnt #(
    .Width (IterW)
  ) u_iter_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (state_q == RUN),
    .clr_i    (abort_act_c),
    .max_i    (n_q),
    .cnt_o    (iter_idx_o),
    .last_c_o (last_c)
  );

  // Status strobes are pure decodes of the state register.
  assign ready_o   = (state_q == IDLE);
  assign load_o    = (state_q == LOAD);
  assign iter_en_o = (state_q == RUN);
  assign valid_o   = (state_q == DONE);
  assign busy_o    = (state_q == LOAD) || (state_q == RUN);

endmodule : cordic_ctrl

// File: tb/tb_cordic_ctrl.sv
// Bench for cordic_ctrl: directed scenarios followed by random traffic, with
// every output compared each cycle against a cycle-offset reference model.
module tb_cordic_ctrl;

  localparam int unsigned Iter  = 16;
  localparam int unsigned IterW = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [IterW:0]   iters_i;
  logic             ack_i;
  logic             ready_o;
  logic             load_o;
  logic             iter_en_o;
  logic [IterW-1:0] iter_idx_o;
  logic             valid_o;
  logic             busy_o;
`ifdef CORDIC_CTRL_ABORT_EN
  logic             abort_i;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: k = cycles since the accepted start (0 = idle), n = clamped count.
  int k = 0;
  int n = 0;

  cordic_ctrl #(.Iterations(Iter)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
`ifdef CORDIC_CTRL_ABORT_EN
    .abort_i    (abort_i),
`endif
    .start_i    (start_i),
    .iters_i    (iters_i),
    .ack_i      (ack_i),
    .ready_o    (ready_o),
    .load_o     (load_o),
    .iter_en_o  (iter_en_o),
    .iter_idx_o (iter_idx_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int clampn(input int req);
    return (req == 0 || req > Iter) ? Iter : req;
  endfunction

  // Expected outputs follow directly from the latency rules:
  // load at k=1, rotations at k=2..n+1 with idx=k-2, valid from k=n+2.
  task automatic check_all();
    bit en_e;
    en_e = (k >= 2) && (k <= n + 1);
    check("ready",   int'(ready_o),    int'(k == 0));
    check("load",    int'(load_o),     int'(k == 1));
    check("iter_en", int'(iter_en_o),  int'(en_e));
    check("idx",     int'(iter_idx_o), en_e ? k - 2 : 0);
    check("valid",   int'(valid_o),    int'(k >= n + 2));
    check("busy",    int'(busy_o),     int'(k == 1 || en_e));
  endtask

  task automatic model_edge();
    bit ab;
    ab = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
    ab = abort_i;
`endif
    if (rst_i) begin
      k = 0;
    end else if (k == 0) begin
      if (start_i) begin
        k = 1;
        n = clampn(int'(iters_i));
      end
    end else if (ab && k <= n + 1) begin
      k = 0;
    end else if (k >= n + 2) begin
      if (ack_i) k = 0;
    end else begin
      k++;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  // One operation: start, run to DONE, hold valid for `hold` cycles while
  // poking start (must be ignored), then ack.
  task automatic run_op(input int req, input int hold);
    start_i = 1'b1;
    iters_i = (IterW+1)'(req);
    ack_i   = 1'b0;
    step();
    start_i = 1'b0;
    iters_i = (IterW+1)'($urandom_range(31));
    repeat (clampn(req) + 1) step();
    check("valid_at_lat", int'(valid_o), 1);
    for (int i = 0; i < hold; i++) begin
      start_i = (i % 2) == 0;
      step();
    end
    start_i = 1'b1;
    ack_i   = 1'b1;
    step();
    check("ready_after_ack", int'(ready_o), 1);
    start_i = 1'b0;
    ack_i   = 1'b0;
    step();
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    iters_i = '0;
    ack_i   = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
    abort_i = 1'b0;
`endif
    #1;
    check_all();
    step();
    step();
    rst_i = 1'b0;
    step();

    run_op(16, 10);
    run_op(0, 2);
    run_op(20, 1);
    run_op(1, 0);
    run_op(7, 3);

    // Asynchronous reset while idx=7.
    start_i = 1'b1;
    iters_i = 5'd16;
    step();
    start_i = 1'b0;
    repeat (8) step();
    check("idx_before_rst", int'(iter_idx_o), 7);
    rst_i = 1'b1;
    #1;
    k = 0;
    check_all();
    step();
    rst_i = 1'b0;
    step();
    run_op(3, 0);

`ifdef CORDIC_CTRL_ABORT_EN
    // Abort at idx=5, then a normal operation.
    start_i = 1'b1;
    iters_i = 5'd16;
    step();
    start_i = 1'b0;
    repeat (6) step();
    check("idx_before_abort", int'(iter_idx_o), 5);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("ready_after_abort", int'(ready_o), 1);
    step();
    run_op(8, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      start_i = ($urandom_range(2) == 0);
      iters_i = (IterW+1)'($urandom_range(31));
      ack_i   = ($urandom_range(1) == 0);
`ifdef CORDIC_CTRL_ABORT_EN
      abort_i = ($urandom_range(9) == 0);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cordic_ctrl
